// File: rtl/trim_fuse_override_secure_ctrl.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | trim_fuse_override_secure_ctrl                                            |
// | IJTAG data register gating the trim-fuse-override secure mux select       |
// | behind an unlock key. Optional macro TRIM_FUSE_OVR_LOCKOUT_EN adds a     |
// | wrong-key fail counter and a sticky LOCKOUT state.                        |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module trim_fuse_override_secure_ctrl #(
    parameter int                KEY_W    = 16,
    parameter logic [KEY_W-1:0]  KEY      = 16'hA5C3,
    parameter int                MAX_FAIL = 3
) (
    input  logic ijtag_tck,
    input  logic ijtag_reset,
    input  logic ijtag_sel,
    input  logic ijtag_ce,
    input  logic ijtag_se,
    input  logic ijtag_ue,
    input  logic ijtag_si,
    output logic ijtag_so,
    input  logic fuse_disable,
    output logic mux_select,
    output logic unlocked
);

    if (KEY_W < 3) begin : g_bad_key_w
        $error("KEY_W must be at least 3");
    end
    if (MAX_FAIL < 1 || MAX_FAIL > 7) begin : g_bad_max_fail
        $error("MAX_FAIL must be in 1..7");
    end

    typedef enum logic [1:0] {
        LOCKED   = 2'b00,
        UNLOCKED = 2'b01,
        LOCKOUT  = 2'b10
    } state_t;

    state_t         state_q, state_d;
    logic [KEY_W:0] sr_q, sr_d;
    logic           sel_q, sel_d;
    logic           w_key_match;
    logic           w_update;

`ifdef TRIM_FUSE_OVR_LOCKOUT_EN
    localparam logic [2:0] MAX_FAIL_C = 3'(MAX_FAIL);
    logic [2:0] fail_q, fail_d;
    logic [2:0] w_fail_inc;
    assign w_fail_inc = (fail_q < MAX_FAIL_C) ? fail_q + 3'd1 : fail_q;
`endif

    assign w_key_match = (sr_q[KEY_W:1] == KEY);
    assign w_update    = ijtag_sel & ~ijtag_ce & ~ijtag_se & ijtag_ue;

    assign unlocked   = (state_q == UNLOCKED);
    assign mux_select = sel_q & (state_q == UNLOCKED);
    assign ijtag_so   = sr_q[0];

    always_comb begin
        sr_d    = sr_q;
        state_d = state_q;
        sel_d   = sel_q;
`ifdef TRIM_FUSE_OVR_LOCKOUT_EN
        fail_d  = fail_q;
`endif
        if (ijtag_sel) begin
            if (ijtag_ce) begin
                sr_d      = '0;
                sr_d[2:0] = {state_q, mux_select};
            end else if (ijtag_se) begin
                sr_d = {ijtag_si, sr_q[KEY_W:1]};
            end
        end

        // Update decisions use the register contents from before this edge.
        if (w_update && state_q != LOCKOUT) begin
            if (w_key_match) begin
                state_d = UNLOCKED;
                sel_d   = sr_q[0];
`ifdef TRIM_FUSE_OVR_LOCKOUT_EN
                fail_d  = 3'd0;
`endif
            end else begin
                state_d = LOCKED;
                sel_d   = 1'b0;
`ifdef TRIM_FUSE_OVR_LOCKOUT_EN
                fail_d  = w_fail_inc;
                if (w_fail_inc == MAX_FAIL_C) begin
                    state_d = LOCKOUT;
                end
`endif
            end
        end

        if (fuse_disable) begin
`ifdef TRIM_FUSE_OVR_LOCKOUT_EN
            state_d = LOCKOUT;
`else
            state_d = LOCKED;
`endif
            sel_d   = 1'b0;
        end
    end

    always_ff @(posedge ijtag_tck) begin
        if (!ijtag_reset) begin
            sr_q    <= '0;
            state_q <= LOCKED;
            sel_q   <= 1'b0;
`ifdef TRIM_FUSE_OVR_LOCKOUT_EN
            fail_q  <= 3'd0;
`endif
        end else begin
            sr_q    <= sr_d;
            state_q <= state_d;
            sel_q   <= sel_d;
`ifdef TRIM_FUSE_OVR_LOCKOUT_EN
            fail_q  <= fail_d;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_trim_fuse_override_secure_ctrl.sv
`default_nettype none
// Randomized bench for trim_fuse_override_secure_ctrl with a behavioural
// reference model plus literal scenario checks.
module tb_trim_fuse_override_secure_ctrl;

    localparam int               KEY_W    = 16;
    localparam logic [KEY_W-1:0] KEY      = 16'hA5C3;
    localparam int               MAX_FAIL = 3;

    logic tck = 1'b0;
    logic rst_n = 1'b0;
    logic sel = 1'b0, ce = 1'b0, se = 1'b0, ue = 1'b0, si = 1'b0, fuse = 1'b0;
    logic so, mux, unl;

    trim_fuse_override_secure_ctrl #(
        .KEY_W(KEY_W), .KEY(KEY), .MAX_FAIL(MAX_FAIL)
    ) dut (
        .ijtag_tck(tck), .ijtag_reset(rst_n), .ijtag_sel(sel), .ijtag_ce(ce),
        .ijtag_se(se), .ijtag_ue(ue), .ijtag_si(si), .ijtag_so(so),
        .fuse_disable(fuse), .mux_select(mux), .unlocked(unl)
    );

    always #5 tck = ~tck;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    // Model: state 0 = LOCKED, 1 = UNLOCKED, 2 = LOCKOUT
    logic [KEY_W:0] m_sr = '0;
    int             m_state = 0;
    bit             m_sel = 1'b0;
    int             m_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [KEY_W:0] nsr;
        int nst, nfail;
        bit nsel, mux_now;
        if (!rst_n) begin
            m_sr = '0; m_state = 0; m_sel = 1'b0; m_fail = 0;
            return;
        end
        nsr = m_sr; nst = m_state; nsel = m_sel; nfail = m_fail;
        mux_now = m_sel && (m_state == 1);
        if (sel) begin
            if (ce) nsr = (KEY_W+1)'(m_state * 2 + int'(mux_now));
            else if (se) nsr = {si, m_sr[KEY_W:1]};
            else if (ue && m_state != 2) begin
                if (m_sr[KEY_W:1] == KEY) begin
                    nst = 1; nsel = m_sr[0]; nfail = 0;
                end else begin
                    nst = 0; nsel = 1'b0;
`ifdef TRIM_FUSE_OVR_LOCKOUT_EN
                    nfail = (m_fail + 1 > MAX_FAIL) ? MAX_FAIL : m_fail + 1;
                    if (nfail == MAX_FAIL) nst = 2;
`endif
                end
            end
        end
`ifdef TRIM_FUSE_OVR_LOCKOUT_EN
        if (fuse) begin nst = 2; nsel = 1'b0; end
`else
        if (fuse) begin nst = 0; nsel = 1'b0; end
`endif
        m_sr = nsr; m_state = nst; m_sel = nsel; m_fail = nfail;
    endtask

    always @(negedge tck) begin
        if (chk_en) begin
            check("so", 32'(so), 32'(m_sr[0]));
            check("unlocked", 32'(unl), 32'(m_state == 1));
            check("mux_select", 32'(mux), 32'(m_sel && m_state == 1));
        end
    end

    task automatic tick();
        @(posedge tck);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; tick(); rst_n = 1'b1;
    endtask

    task automatic shift_word(input logic [KEY_W:0] w);
        se = 1'b1;
        for (int i = 0; i <= KEY_W; i++) begin
            si = w[i];
            tick();
        end
        se = 1'b0; si = 1'b0;
    endtask

    task automatic do_update();
        ue = 1'b1; tick(); ue = 1'b0;
    endtask

    task automatic do_capture();
        ce = 1'b1; tick(); ce = 1'b0;
    endtask

    task automatic read_bits(input int n, output logic [31:0] v);
        v = '0;
        se = 1'b1; si = 1'b0;
        for (int i = 0; i < n; i++) begin
            v[i] = so;
            tick();
        end
        se = 1'b0;
    endtask

    logic [31:0] rd;

    initial begin
        sel = 1'b1;
        tick(); tick();
        chk_en = 1'b1;
        rst_n = 1'b1;
        check("reset_unlocked", 32'(unl), 32'd0);
        check("reset_mux", 32'(mux), 32'd0);

        // Reset capture reads all zeros
        do_capture();
        read_bits(KEY_W + 1, rd);
        check("reset_capture", rd, 32'd0);

        // Good key with select
        shift_word({KEY, 1'b1});
        do_update();
        check("unlock_unl", 32'(unl), 32'd1);
        check("unlock_mux", 32'(mux), 32'd1);
        do_capture();
        read_bits(3, rd);
        check("unlock_capture", rd, 32'b011);

        // Good key, select 0; then a wrong key relocks
        shift_word({KEY, 1'b0});
        do_update();
        check("desel_mux", 32'(mux), 32'd0);
        check("desel_unl", 32'(unl), 32'd1);
        shift_word({16'h0000, 1'b1});
        do_update();
        check("badkey_unl", 32'(unl), 32'd0);
        check("badkey_mux", 32'(mux), 32'd0);

        // Repeated wrong keys then a good key
        for (int k = 0; k < 3; k++) begin
            shift_word({16'h1234, 1'b1});
            do_update();
        end
        shift_word({KEY, 1'b1});
        do_update();
        do_capture();
        read_bits(3, rd);
`ifdef TRIM_FUSE_OVR_LOCKOUT_EN
        check("lockout_capture", rd, 32'b100);
        check("lockout_mux", 32'(mux), 32'd0);
`else
        check("nolockout_capture", rd, 32'b011);
        check("nolockout_mux", 32'(mux), 32'd1);
`endif
        do_reset();
        shift_word({KEY, 1'b1});
        do_update();
        check("post_reset_unl", 32'(unl), 32'd1);

        // Fuse pulse while unlocked
        fuse = 1'b1; tick(); fuse = 1'b0;
        check("fuse_mux", 32'(mux), 32'd0);
        shift_word({KEY, 1'b1});
        do_update();
`ifdef TRIM_FUSE_OVR_LOCKOUT_EN
        check("fuse_sticky_unl", 32'(unl), 32'd0);
`else
        check("fuse_release_unl", 32'(unl), 32'd1);
`endif

        // Update and fuse together
        do_reset();
        shift_word({KEY, 1'b1});
        ue = 1'b1; fuse = 1'b1; tick(); ue = 1'b0; fuse = 1'b0;
        check("ue_fuse_mux", 32'(mux), 32'd0);
        check("ue_fuse_unl", 32'(unl), 32'd0);

        // Deselected segment ignores enables
        do_reset();
        shift_word({KEY, 1'b1});
        do_update();
        shift_word({16'h0BAD, 1'b0});
        sel = 1'b0;
        do_update();
        do_capture();
        check("desel_hold_unl", 32'(unl), 32'd1);
        check("desel_hold_mux", 32'(mux), 32'd1);
        sel = 1'b1;

        // Randomized episodes
        for (int ep = 0; ep < 150; ep++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: begin shift_word({KEY, 1'($urandom_range(0, 1))}); do_update(); end
                3, 4:    begin shift_word({16'($urandom), 1'($urandom_range(0, 1))}); do_update(); end
                5:       begin fuse = 1'b1; tick(); fuse = 1'b0; end
                6:       if ($urandom_range(0, 2) == 0) do_reset();
                default: begin
                    for (int c = 0; c < 12; c++) begin
                        sel  = ($urandom_range(0, 9) != 0);
                        ce   = ($urandom_range(0, 9) == 0);
                        se   = ($urandom_range(0, 1) == 0);
                        ue   = ($urandom_range(0, 4) == 0);
                        si   = 1'($urandom_range(0, 1));
                        fuse = ($urandom_range(0, 49) == 0);
                        rst_n = ($urandom_range(0, 49) != 0);
                        tick();
                    end
                    sel = 1'b1; ce = 1'b0; se = 1'b0; ue = 1'b0; fuse = 1'b0; rst_n = 1'b1;
                end
            endcase
            if ($urandom_range(0, 3) == 0) begin
                do_capture();
                read_bits(3, rd);
            end
        end

        @(negedge tck);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
